mem_port_arbiter: RTL and testbench

- Shares the single memory-controller data port between two requesters: the core load/store path and the CRAS spill/fill path.
- Grants one transaction at a time and stalls the core through core_hold while its access is pending.
- Returns read data and completion pulses to each requester.
- Aborts any transaction that exceeds a cycle timeout and raises a sticky error flag.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory-controller data port between the core
//   load/store path and the CRAS spill/fill path. Only one transaction is in
//   flight at a time. The core is stalled through core_hold while its access
//   is pending. Transactions that wait too long for m_ack are aborted, and a
//   sticky error flag is raised.
//
// Ports
//   clk, Rst             clock, asynchronous active-high reset
//   core_req/we/addr/    core requester; req is a level held until core_ack
//   wdata/be
//   core_rdata/ack/hold  load data with its ack pulse, core stall
//   ras_rd/wr/addr/wdata CRAS requester; rd/wr levels held until ras_rdy
//   ras_rdata/rdy        fill data with its completion pulse
//   m_req/we/addr/       downstream request, registered on grant and held
//   wdata/be             stable for the whole access
//   m_ack/m_rdata        downstream completion pulse and read data
//   timeout_err/err_clr  sticky timeout flag and its clear
//   owner                current or last grant (0 = core, 1 = CRAS)
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter bit RAS_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_ack,
  output logic                core_hold,
  input  logic                ras_rd,
  input  logic                ras_wr,
  input  logic [ADDR_W-1:0]   ras_addr,
  input  logic [DATA_W-1:0]   ras_wdata,
  output logic [DATA_W-1:0]   ras_rdata,
  output logic                ras_rdy,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                timeout_err,
  input  logic                err_clr,
  output logic                owner
);

  localparam int BE_W  = DATA_W / 8;
  // The counter only has to reach TIMEOUT-1; the abort fires on the cycle
  // whose increment would reach TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_CORE, BUSY_RAS, RESP} state_t;

  state_t              state_q, state_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]   ras_rdata_q, ras_rdata_d;
  logic                core_ack_q, core_ack_d;
  logic                ras_rdy_q, ras_rdy_d;
  logic                timeout_err_q, timeout_err_d;
  logic                owner_q, owner_d;
  logic                last_ras_q, last_ras_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                ras_any;
  logic                core_wins;
  logic                timed_out;

  // Next-state logic. Arbitration happens only in IDLE. RESP is a single
  // cycle that carries the completion pulse, so the requester can drop its
  // level before the next grant decision.
  always_comb begin
    state_d       = state_q;
    m_req_d       = m_req_q;
    m_we_d        = m_we_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    m_be_d        = m_be_q;
    core_rdata_d  = core_rdata_q;
    ras_rdata_d   = ras_rdata_q;
    core_ack_d    = 1'b0;
    ras_rdy_d     = 1'b0;
    owner_d       = owner_q;
    last_ras_d    = last_ras_q;
    cnt_d         = cnt_q;
    // A new timeout is applied after the clear, so it wins over err_clr.
    timeout_err_d = timeout_err_q & ~err_clr;

    ras_any   = ras_rd | ras_wr;
    // On a tie the core wins only under round-robin when CRAS was served last.
    core_wins = core_req & (~ras_any | (~RAS_PRIO & last_ras_q));
    timed_out = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

    case (state_q)
      IDLE: begin
        if (core_wins) begin
          state_d    = BUSY_CORE;
          m_req_d    = 1'b1;
          m_we_d     = core_we;
          m_addr_d   = core_addr;
          m_wdata_d  = core_wdata;
          m_be_d     = core_be;
          owner_d    = 1'b0;
          last_ras_d = 1'b0;
          cnt_d      = '0;
        end else if (ras_any) begin
          state_d    = BUSY_RAS;
          m_req_d    = 1'b1;
          m_we_d     = ras_wr;
          m_addr_d   = ras_addr;
          m_wdata_d  = ras_wdata;
          m_be_d     = '1;
          owner_d    = 1'b1;
          last_ras_d = 1'b1;
          cnt_d      = '0;
        end
      end
      BUSY_CORE, BUSY_RAS: begin
        // m_ack is tested first, so an ack arriving in the timeout cycle
        // completes normally without raising the error.
        if (m_ack || timed_out) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (state_q == BUSY_CORE) begin
            core_ack_d = 1'b1;
          end else begin
            ras_rdy_d = 1'b1;
          end
          if (!m_ack) begin
            timeout_err_d = 1'b1;
            if (state_q == BUSY_CORE) begin
              core_rdata_d = '0;
            end else begin
              ras_rdata_d = '0;
            end
          end else if (!m_we_q) begin
            if (state_q == BUSY_CORE) begin
              core_rdata_d = m_rdata;
            end else begin
              ras_rdata_d = m_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. The last-grant pointer resets to CRAS so
  // that the core wins the first tie.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= IDLE;
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_be_q        <= '0;
      core_rdata_q  <= '0;
      ras_rdata_q   <= '0;
      core_ack_q    <= 1'b0;
      ras_rdy_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      owner_q       <= 1'b0;
      last_ras_q    <= 1'b1;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      m_req_q       <= m_req_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_be_q        <= m_be_d;
      core_rdata_q  <= core_rdata_d;
      ras_rdata_q   <= ras_rdata_d;
      core_ack_q    <= core_ack_d;
      ras_rdy_q     <= ras_rdy_d;
      timeout_err_q <= timeout_err_d;
      owner_q       <= owner_d;
      last_ras_q    <= last_ras_d;
      cnt_q         <= cnt_d;
    end
  end

  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_be        = m_be_q;
  assign core_rdata  = core_rdata_q;
  assign ras_rdata   = ras_rdata_q;
  assign core_ack    = core_ack_q;
  assign ras_rdy     = ras_rdy_q;
  assign timeout_err = timeout_err_q;
  assign owner       = owner_q;
  // The stall drops in the ack cycle itself, so the core can move on then.
  assign core_hold   = core_req & ~core_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiters run side by side. Instance 0 uses round-robin with
//   TIMEOUT=4, and instance 1 uses CRAS priority with the timeout disabled.
//   The bench acts as both requesters and as the downstream memory. It keeps a
//   transaction-level model of the expected grants, data and error flag.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst        [2];
  logic        core_req   [2];
  logic        core_we    [2];
  logic [31:0] core_addr  [2];
  logic [31:0] core_wdata [2];
  logic [3:0]  core_be    [2];
  logic [31:0] core_rdata [2];
  logic        core_ack   [2];
  logic        core_hold  [2];
  logic        ras_rd     [2];
  logic        ras_wr     [2];
  logic [31:0] ras_addr   [2];
  logic [31:0] ras_wdata  [2];
  logic [31:0] ras_rdata  [2];
  logic        ras_rdy    [2];
  logic        m_req      [2];
  logic        m_we       [2];
  logic [31:0] m_addr     [2];
  logic [31:0] m_wdata    [2];
  logic [3:0]  m_be       [2];
  logic        m_ack      [2];
  logic [31:0] m_rdata    [2];
  logic        timeout_err[2];
  logic        err_clr    [2];
  logic        owner      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT ((g == 0) ? 4 : 0),
      .RAS_PRIO(g == 1)
    ) u_dut (
      .clk        (clk),
      .Rst        (Rst[g]),
      .core_req   (core_req[g]),
      .core_we    (core_we[g]),
      .core_addr  (core_addr[g]),
      .core_wdata (core_wdata[g]),
      .core_be    (core_be[g]),
      .core_rdata (core_rdata[g]),
      .core_ack   (core_ack[g]),
      .core_hold  (core_hold[g]),
      .ras_rd     (ras_rd[g]),
      .ras_wr     (ras_wr[g]),
      .ras_addr   (ras_addr[g]),
      .ras_wdata  (ras_wdata[g]),
      .ras_rdata  (ras_rdata[g]),
      .ras_rdy    (ras_rdy[g]),
      .m_req      (m_req[g]),
      .m_we       (m_we[g]),
      .m_addr     (m_addr[g]),
      .m_wdata    (m_wdata[g]),
      .m_be       (m_be[g]),
      .m_ack      (m_ack[g]),
      .m_rdata    (m_rdata[g]),
      .timeout_err(timeout_err[g]),
      .err_clr    (err_clr[g]),
      .owner      (owner[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance
  bit          lastRas  [2];
  bit          ownerExp [2];
  bit          errExp   [2];
  logic [31:0] coreRdExp[2];
  logic [31:0] rasRdExp [2];
  bit          corePend [2];
  bit          rasPend  [2];

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel(input int d);
    lastRas[d]   = 1'b1;
    ownerExp[d]  = 1'b0;
    errExp[d]    = 1'b0;
    coreRdExp[d] = '0;
    rasRdExp[d]  = '0;
    corePend[d]  = 1'b0;
    rasPend[d]   = 1'b0;
  endtask

  task automatic clearInputs(input int d);
    core_req[d] = 0; core_we[d] = 0; core_addr[d] = '0; core_wdata[d] = '0;
    core_be[d] = '0; ras_rd[d] = 0; ras_wr[d] = 0; ras_addr[d] = '0;
    ras_wdata[d] = '0; m_ack[d] = 0; m_rdata[d] = '0; err_clr[d] = 0;
  endtask

  task automatic doReset();
    for (int d = 0; d < 2; d++) begin
      Rst[d] = 1'b1;
      clearInputs(d);
      resetModel(d);
    end
    repeat (2) @(posedge clk);
    #1;
    Rst[0] = 1'b0;
    Rst[1] = 1'b0;
  endtask

  task automatic raiseCore(input int d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    core_req[d] = 1'b1; core_we[d] = we; core_addr[d] = addr;
    core_wdata[d] = wdata; core_be[d] = be;
    corePend[d] = 1'b1;
  endtask

  // mode bit 0 = fill (rd), bit 1 = spill (wr)
  task automatic raiseRas(input int d, input logic [1:0] mode,
                          input logic [31:0] addr, input logic [31:0] wdata);
    ras_rd[d] = mode[0]; ras_wr[d] = mode[1];
    ras_addr[d] = addr; ras_wdata[d] = wdata;
    rasPend[d] = 1'b1;
  endtask

  // One complete transaction, starting in an IDLE cycle with the requests
  // already raised. lat is the number of BUSY cycles before memory acks.
  // clrWhen: 0 none, 1 err_clr in the first BUSY cycle, 2 in the last.
  task automatic applyStimulus(input int d, input int lat, input int clrWhen,
                               input bit strayIdle, input bit strayResp,
                               input logic [31:0] rdVal, output bit wonRas);
    bit          ras;
    bit          isWr;
    bit          timedOut;
    int          limit;
    int          busyCycles;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;

    limit = (d == 0) ? 4 : 0;
    if (corePend[d] && rasPend[d]) ras = (d == 1) ? 1'b1 : !lastRas[d];
    else ras = rasPend[d];
    isWr     = ras ? ras_wr[d] : core_we[d];
    expAddr  = ras ? ras_addr[d] : core_addr[d];
    expWdata = ras ? ras_wdata[d] : core_wdata[d];
    expBe    = ras ? 4'hF : core_be[d];
    timedOut = (limit > 0) && (lat >= limit);
    busyCycles = timedOut ? limit : lat + 1;

    // IDLE cycle: grant decided here, nothing on the downstream port yet
    m_ack[d] = strayIdle;
    m_rdata[d] = $urandom;
    @(negedge clk);
    checkOutput("idle_mreq", 32'(m_req[d]), 0);
    checkOutput("idle_hold", 32'(core_hold[d]), 32'(corePend[d]));
    checkOutput("idle_err", 32'(timeout_err[d]), 32'(errExp[d]));
    checkOutput("idle_owner", 32'(owner[d]), 32'(ownerExp[d]));
    lastRas[d]  = ras;
    ownerExp[d] = ras;

    for (int i = 0; i < busyCycles; i++) begin
      nextCycle();
      m_ack[d]   = !timedOut && (i == lat);
      m_rdata[d] = (i == lat) ? rdVal : 32'($urandom);
      err_clr[d] = ((clrWhen == 1) && (i == 0)) ||
                   ((clrWhen == 2) && (i == busyCycles - 1));
      @(negedge clk);
      checkOutput("busy_mreq", 32'(m_req[d]), 1);
      checkOutput("busy_maddr", m_addr[d], expAddr);
      checkOutput("busy_acks", {30'd0, core_ack[d], ras_rdy[d]}, 0);
      checkOutput("busy_hold", 32'(core_hold[d]), 32'(corePend[d]));
      if (i == 0) begin
        checkOutput("grant_owner", 32'(owner[d]), 32'(ras));
        checkOutput("grant_mwe", 32'(m_we[d]), 32'(isWr));
        checkOutput("grant_mwdata", m_wdata[d], expWdata);
        checkOutput("grant_mbe", 32'(m_be[d]), 32'(expBe));
      end
    end

    // RESP cycle
    nextCycle();
    m_ack[d]   = strayResp;
    err_clr[d] = 1'b0;
    if (timedOut) errExp[d] = 1'b1;
    else if (clrWhen != 0) errExp[d] = 1'b0;
    if (timedOut) begin
      if (ras) rasRdExp[d] = '0;
      else coreRdExp[d] = '0;
    end else if (!isWr) begin
      if (ras) rasRdExp[d] = rdVal;
      else coreRdExp[d] = rdVal;
    end
    @(negedge clk);
    checkOutput("resp_mreq", 32'(m_req[d]), 0);
    checkOutput("resp_core_ack", 32'(core_ack[d]), 32'(!ras));
    checkOutput("resp_ras_rdy", 32'(ras_rdy[d]), 32'(ras));
    checkOutput("resp_core_rdata", core_rdata[d], coreRdExp[d]);
    checkOutput("resp_ras_rdata", ras_rdata[d], rasRdExp[d]);
    checkOutput("resp_err", 32'(timeout_err[d]), 32'(errExp[d]));
    checkOutput("resp_hold", 32'(core_hold[d]), 32'(corePend[d] && ras));

    // Requester drops its level the cycle after the pulse
    nextCycle();
    m_ack[d] = 1'b0;
    if (ras) begin
      ras_rd[d] = 1'b0; ras_wr[d] = 1'b0; rasPend[d] = 1'b0;
    end else begin
      core_req[d] = 1'b0; corePend[d] = 1'b0;
    end
    wonRas = ras;
  endtask

  task automatic drain(input int d);
    bit won;
    while (corePend[d] || rasPend[d]) applyStimulus(d, 1, 0, 0, 0, $urandom, won);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit won;
    int lat;

    // Reset values on both instances
    doReset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_mreq", 32'(m_req[d]), 0);
      checkOutput("rst_mwe", 32'(m_we[d]), 0);
      checkOutput("rst_maddr", m_addr[d], 0);
      checkOutput("rst_mwdata", m_wdata[d], 0);
      checkOutput("rst_mbe", 32'(m_be[d]), 0);
      checkOutput("rst_acks", {30'd0, core_ack[d], ras_rdy[d]}, 0);
      checkOutput("rst_core_rdata", core_rdata[d], 0);
      checkOutput("rst_ras_rdata", ras_rdata[d], 0);
      checkOutput("rst_err", 32'(timeout_err[d]), 0);
      checkOutput("rst_owner", 32'(owner[d]), 0);
      checkOutput("rst_hold", 32'(core_hold[d]), 0);
    end
    nextCycle();

    // Core load alone, memory acks two cycles after m_req
    $display("[TB] core load alone");
    raiseCore(0, 1'b0, 32'h100, 32'h0, 4'hF);
    applyStimulus(0, 2, 0, 0, 0, 32'hCAFEF00D, won);
    checkOutput("load_rdata", core_rdata[0], 32'hCAFEF00D);

    // Ties from reset: round-robin alternates, CRAS priority always wins
    for (int d = 0; d < 2; d++) begin
      $display("[TB] tie arbitration on instance %0d", d);
      doReset();
      raiseCore(d, 1'b1, 32'h200, 32'hA5A5A5A5, 4'h3);
      raiseRas(d, 2'b10, 32'h300, 32'h12345678);
      for (int k = 0; k < 4; k++) begin
        applyStimulus(d, 1, 0, 0, 0, $urandom, won);
        checkOutput("tie_order", 32'(won), (d == 1) ? 32'd1 : 32'(k % 2));
        if (won) raiseRas(d, 2'b10, 32'h300, 32'h12345678);
        else raiseCore(d, 1'b1, 32'h200, 32'hA5A5A5A5, 4'h3);
      end
      drain(d);
    end

    // Timeout: never-acked core store, clear, and clear colliding with timeout
    $display("[TB] timeout behaviour");
    doReset();
    raiseCore(0, 1'b1, 32'h400, 32'h11112222, 4'hF);
    applyStimulus(0, 20, 0, 0, 0, $urandom, won);
    checkOutput("to_err_held", 32'(timeout_err[0]), 1);
    err_clr[0] = 1'b1;
    nextCycle();
    err_clr[0] = 1'b0;
    errExp[0] = 1'b0;
    @(negedge clk);
    checkOutput("to_err_cleared", 32'(timeout_err[0]), 0);
    nextCycle();
    raiseCore(0, 1'b0, 32'h404, 32'h0, 4'hF);
    applyStimulus(0, 3, 0, 0, 0, 32'h0BADBEEF, won);
    checkOutput("ack_at_limit_no_err", 32'(timeout_err[0]), 0);
    raiseCore(0, 1'b1, 32'h408, 32'h33334444, 4'hF);
    applyStimulus(0, 20, 2, 0, 1, $urandom, won);
    checkOutput("to_err_clr_same_cycle", 32'(timeout_err[0]), 1);

    // Stray m_ack with no requests: no pulse, owner unchanged
    $display("[TB] stray ack in IDLE");
    m_ack[0] = 1'b1;
    nextCycle();
    m_ack[0] = 1'b0;
    @(negedge clk);
    checkOutput("stray_acks", {30'd0, core_ack[0], ras_rdy[0]}, 0);
    checkOutput("stray_owner", 32'(owner[0]), 32'(ownerExp[0]));
    checkOutput("stray_mreq", 32'(m_req[0]), 0);
    nextCycle();

    // Randomised traffic on both instances
    for (int d = 0; d < 2; d++) begin
      $display("[TB] random traffic on instance %0d", d);
      doReset();
      for (int r = 0; r < 40; r++) begin
        if (!corePend[d] && ($urandom_range(0, 1) == 1))
          raiseCore(d, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
        if (!rasPend[d] && ($urandom_range(0, 1) == 1))
          raiseRas(d, 2'($urandom_range(1, 3)), $urandom, $urandom);
        if (!corePend[d] && !rasPend[d])
          raiseCore(d, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
        lat = $urandom_range(0, (d == 0) ? 6 : 8);
        applyStimulus(d, lat, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, won);
      end
      drain(d);
    end

    // Both ras_rd and ras_wr high is a write
    raiseRas(1, 2'b11, 32'h500, 32'h55AA55AA);
    applyStimulus(1, 0, 0, 0, 0, $urandom, won);
    checkOutput("rdwr_keeps_rdata", ras_rdata[1], rasRdExp[1]);

    // Reset mid-transaction on instance 1, then a late m_ack
    $display("[TB] reset during BUSY_RAS");
    raiseRas(1, 2'b01, 32'h600, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("midrst_busy_mreq", 32'(m_req[1]), 1);
    nextCycle();
    Rst[1] = 1'b1;
    #1;
    checkOutput("midrst_mreq", 32'(m_req[1]), 0);
    checkOutput("midrst_maddr", m_addr[1], 0);
    checkOutput("midrst_owner", 32'(owner[1]), 0);
    checkOutput("midrst_ras_rdy", 32'(ras_rdy[1]), 0);
    checkOutput("midrst_ras_rdata", ras_rdata[1], 0);
    clearInputs(1);
    resetModel(1);
    nextCycle();
    Rst[1] = 1'b0;
    nextCycle();
    m_ack[1] = 1'b1;
    m_rdata[1] = 32'hDEADDEAD;
    @(negedge clk);
    checkOutput("late_ack_mreq", 32'(m_req[1]), 0);
    nextCycle();
    m_ack[1] = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_rdy", 32'(ras_rdy[1]), 0);
    checkOutput("late_ack_rdata", ras_rdata[1], 0);
    nextCycle();
    raiseRas(1, 2'b01, 32'h700, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 32'h77778888, won);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
